// File: rtl/mem_access_unit.sv
// Load/store front-end for a word-wide, falling-edge data RAM: byte/half/word loads with extension, sub-word stores by read-modify-write.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses skip memory and respond with a misalign flag.
module mem_access_unit #(
  parameter int MEM_AW = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [31:0] mem_rdata,
`ifdef MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_e;

  state_e      state_q, state_d;
  logic        ready_en_q;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [1:0]  lane_q, lane_d;
  logic [15:0] wdata_q, wdata_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;

  logic        accept;
  logic [1:0]  req_sz;
  logic [1:0]  req_lane;
  logic        req_mis;
  logic [31:0] shifted;
  logic [31:0] load_val;
  logic [31:0] lane_mask;
  logic [31:0] merged;
  logic        unused_addr_bits;

  assign unused_addr_bits = ^req_addr[31:MEM_AW+2];

  // Size 11 behaves as a word; the lane is the aligned-down byte offset.
  always_comb begin
    req_sz = (req_size == 2'b11) ? 2'b10 : req_size;
    case (req_sz)
      2'b00:   req_lane = req_addr[1:0];
      2'b01:   req_lane = {req_addr[1], 1'b0};
      default: req_lane = 2'b00;
    endcase
`ifdef MISALIGN_TRAP_EN
    req_mis = ((req_sz == 2'b01) && req_addr[0]) ||
              ((req_sz == 2'b10) && (req_addr[1:0] != 2'b00));
`else
    req_mis = 1'b0;
`endif
  end

  assign accept = req_valid && req_ready;

  always_comb begin
    shifted = mem_rdata >> {lane_q, 3'b000};
    case (size_q)
      2'b00:   load_val = {{24{signed_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = {{16{signed_q & shifted[15]}}, shifted[15:0]};
      default: load_val = mem_rdata;
    endcase
    lane_mask = (size_q == 2'b00) ? (32'h0000_00FF << {lane_q, 3'b000})
                                  : (32'h0000_FFFF << {lane_q, 3'b000});
    merged    = (mem_rdata & ~lane_mask) | (({16'd0, wdata_q} << {lane_q, 3'b000}) & lane_mask);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_mis)                      state_d = RESP;
          else if (req_we && req_sz == 2'b10) state_d = WRITE;
          else                              state_d = READ;
        end
      end
      READ:    state_d = we_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the state register so reset drops strobes immediately
  always_comb begin
    req_ready = ready_en_q && (state_q == IDLE);
    mem_re    = (state_q == READ);
    mem_we    = (state_q == WRITE);
    rsp_valid = (state_q == RESP);
  end

  always_comb begin
    we_d        = we_q;
    size_d      = size_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d       = req_we;
          size_d     = req_sz;
          signed_d   = req_signed;
          lane_d     = req_lane;
          wdata_d    = req_wdata[15:0];
          mem_addr_d = {{(32-MEM_AW){1'b0}}, req_addr[MEM_AW+1:2]};
          if (req_mis)                             rsp_rdata_d = 32'd0;
          else if (req_we && req_sz == 2'b10)      mem_wdata_d = req_wdata;
        end
      end
      READ: begin
        if (we_q) mem_wdata_d = merged;
        else      rsp_rdata_d = load_val;
      end
      WRITE:   rsp_rdata_d = 32'd0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      signed_q    <= 1'b0;
      lane_q      <= 2'b00;
      wdata_q     <= 16'd0;
      mem_addr_q  <= 32'd0;
      mem_wdata_q <= 32'd0;
      rsp_rdata_q <= 32'd0;
    end else begin
      we_q        <= we_d;
      size_q      <= size_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      wdata_q     <= wdata_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q, mis_d;

  always_comb begin
    mis_d = mis_q;
    if (state_q == IDLE && accept) mis_d = req_mis;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mis_q <= 1'b0;
    else        mis_q <= mis_d;
  end

  assign misalign = (state_q == RESP) && mis_q;
`endif

  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: falling-edge RAM model, byte-array reference memory, directed then random requests.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
  logic [1:0]  dbg_state;
`ifdef MISALIGN_TRAP_EN
  logic        misalign;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] ram [64];
  logic [7:0]  ref_mem [256];
  logic        tb_init;
  logic [5:0]  tb_idx;
  logic [31:0] tb_val;

  mem_access_unit #(.MEM_AW(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_re     (mem_re),
    .mem_rdata  (mem_rdata),
`ifdef MISALIGN_TRAP_EN
    .misalign   (misalign),
`endif
    .dbg_state_o(dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Word RAM sampling on the falling edge
  always @(negedge clk) begin
    if (tb_init)     ram[tb_idx] <= tb_val;
    else if (mem_we) ram[mem_addr[5:0]] <= mem_wdata;
    if (mem_re)      mem_rdata <= ram[mem_addr[5:0]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [5:0] w);
    return {ref_mem[{w, 2'd3}], ref_mem[{w, 2'd2}], ref_mem[{w, 2'd1}], ref_mem[{w, 2'd0}]};
  endfunction

  // Drives one request from a negedge, tracks it to the response, checks against the byte model.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sgn,
                        input logic [31:0] addr, input logic [31:0] wd);
    logic [7:0]  a, al;
    logic [31:0] exp_rd, exp_wd, exp_ma, got_wd, got_ma;
    int          nbytes, exp_lat, exp_re, exp_we, lat, n_re, n_we, guard;
    bit          mis;
    a      = addr[7:0];
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis    = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis = ((nbytes == 2) && a[0]) || ((nbytes == 4) && (a[1:0] != 2'b00));
`endif
    al     = a & ~(8'(nbytes) - 8'd1);
    exp_ma = {26'd0, a[7:2]};
    exp_rd = 32'd0;
    exp_wd = 32'd0;
    if (mis) begin
      exp_lat = 1; exp_re = 0; exp_we = 0;
    end else if (we) begin
      for (int i = 0; i < nbytes; i++) ref_mem[al + 8'(i)] = wd[8*i +: 8];
      exp_wd  = ref_word(a[7:2]);
      exp_lat = (nbytes == 4) ? 2 : 3;
      exp_re  = (nbytes == 4) ? 0 : 1;
      exp_we  = 1;
    end else begin
      for (int i = 0; i < nbytes; i++) exp_rd = exp_rd | (32'(ref_mem[al + 8'(i)]) << (8*i));
      if (sgn && nbytes < 4 && exp_rd[8*nbytes-1]) exp_rd = exp_rd | (32'hFFFF_FFFF << (8*nbytes));
      exp_lat = 2; exp_re = 1; exp_we = 0;
    end

    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    guard = 0;
    while (!req_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("ready_before_accept", {31'd0, req_ready}, 32'd1);

    @(posedge clk); #1;
    // Busy-time garbage on the request bus must be ignored
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    lat = 0; n_re = 0; n_we = 0; got_wd = 32'd0;
    got_ma = mem_addr;
    for (int c = 1; c <= 8; c++) begin
      if (mem_re) n_re++;
      if (mem_we) begin
        n_we++;
        got_wd = mem_wdata;
      end
      if (rsp_valid) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;

    chk("rsp_latency", 32'(lat), 32'(exp_lat));
    chk("mem_re_cycles", 32'(n_re), 32'(exp_re));
    chk("mem_we_cycles", 32'(n_we), 32'(exp_we));
    chk("rsp_rdata", rsp_rdata, exp_rd);
    chk("ready_low_in_resp", {31'd0, req_ready}, 32'd0);
    if (!mis) chk("mem_addr", got_ma, exp_ma);
    if (we && !mis) chk("mem_wdata", got_wd, exp_wd);
`ifdef MISALIGN_TRAP_EN
    chk("misalign", {31'd0, misalign}, {31'd0, mis});
`endif

    @(posedge clk); #1;
    chk("rsp_single_pulse", {31'd0, rsp_valid}, 32'd0);
    chk("rsp_rdata_held", rsp_rdata, exp_rd);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    tb_init = 1'b1; tb_idx = 6'd0; tb_val = 32'd0;
    #2 rst_n = 1'b0;

    // Fill RAM and the reference byte memory while reset is held
    #1;
    for (int w = 0; w < 64; w++) begin
      tb_idx = 6'(w);
      tb_val = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[w*4 + b] = tb_val[8*b +: 8];
      @(negedge clk); #1;
    end
    tb_init = 1'b0;

    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_re", {31'd0, mem_re}, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
`ifdef MISALIGN_TRAP_EN
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_low_at_release", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_release", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    // Directed accesses around word 0xDEADBEEF @0x10
    do_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF);
    chk("sw_mem_addr", mem_addr, 32'd4);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("lw_dir", rsp_rdata, 32'hDEADBEEF);
    do_req(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
    chk("lb_dir", rsp_rdata, 32'hFFFFFFDE);
    do_req(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
    chk("lbu_dir", rsp_rdata, 32'h000000DE);
    do_req(1'b0, 2'd1, 1'b1, 32'h12, 32'h0);
    chk("lh_dir", rsp_rdata, 32'hFFFFDEAD);
    do_req(1'b0, 2'd1, 1'b0, 32'h10, 32'h0);
    chk("lhu_dir", rsp_rdata, 32'h0000BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h12, 32'h0);
`ifdef MISALIGN_TRAP_EN
    chk("lw_misaligned_dir", rsp_rdata, 32'h0);
`else
    chk("lw_misaligned_dir", rsp_rdata, 32'hDEADBEEF);
`endif
    do_req(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000005A);
    chk("sb_merge_dir", mem_wdata, 32'hDEAD5AEF);

    // Reset during the write phase of a byte store: the write must not land
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h000000A5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rmw_read_phase", {31'd0, mem_re}, 32'd1);
    @(posedge clk); #1;
    chk("rmw_write_phase", {31'd0, mem_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_drops_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mid_ready", {31'd0, req_ready}, 32'd0);
    chk("rst_mid_mem_addr", mem_addr, 32'd0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); #1;
      chk("rst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("ready_low_at_release2", {31'd0, req_ready}, 32'd0);
    @(posedge clk); #1;
    chk("ready_after_release2", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
    chk("word_unchanged_after_rst", rsp_rdata, 32'hDEAD5AEF);

    // Address wrap
    do_req(1'b1, 2'd2, 1'b0, 32'h100, 32'h12345678);
    chk("wrap_mem_addr", mem_addr, 32'd0);
    do_req(1'b0, 2'd2, 1'b0, 32'h000, 32'h0);
    chk("wrap_lw", rsp_rdata, 32'h12345678);
    do_req(1'b0, 2'd3, 1'b0, 32'h000, 32'h0);
    chk("size3_as_word", rsp_rdata, 32'h12345678);

    // Random traffic
    for (int n = 0; n < 200; n++) begin
      do_req(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             32'($urandom_range(0, 1023)), $urandom);
    end

    for (int w = 0; w < 64; w++) chk("ram_final", ram[w], ref_word(6'(w)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
